deal_engine: RTL and testbench

//  Parametrised successor to the fixed 7-column setup logic. Builds an ordered deck,

---
 rtl/deal_engine_pkg.sv | 41 ++++
 rtl/deal_engine_lfsr.sv | 44 ++++
 rtl/deal_engine.sv | 215 +++++++++++++++++++++
 tb/tb_deal_engine.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deal_engine_pkg.sv
// Shared card encoding, suit codes, LFSR taps and deal FSM states.
package deal_engine_pkg;

  // Card word layout: [6:3] rank 1..13, [2:1] suit, [0] face-up.
  localparam int CARD_W   = 7;
  localparam int RANK_MSB = 6;
  localparam int RANK_LSB = 3;
  localparam int SUIT_MSB = 2;
  localparam int SUIT_LSB = 1;
  localparam int FACE_UP  = 0;

  localparam logic [1:0] SUIT_HEARTS   = 2'd0;
  localparam logic [1:0] SUIT_SPADES   = 2'd1;
  localparam logic [1:0] SUIT_DIAMONDS = 2'd2;
  localparam logic [1:0] SUIT_CLUBS    = 2'd3;

  // Galois feedback taps for the 16-bit shuffle LFSR.
  localparam logic [15:0] LFSR_TAPS16 = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUILD,
    ST_SHUFFLE,
    ST_DEAL,
    ST_STOCK,
    ST_DONE
  } deal_state_t;

  // Rank and suit only; the face bit is not stored, it is decided at output time.
  typedef logic [CARD_W-2:0] card_id_t;

  // Card identity for ordered-deck position k: rank k/4+1, suit k%4.
  function automatic card_id_t card_id(input int k);
    card_id_t id;
    id = '0;
    id[RANK_MSB-1:RANK_LSB-1] = 4'(k / 4 + 1);
    id[SUIT_MSB-1:SUIT_LSB-1] = 2'(k % 4);
    return id;
  endfunction

endpackage

// File: rtl/deal_engine_lfsr.sv
// Galois LFSR used to draw shuffle swap candidates. Seed 0 is replaced by 1 so
// the register can never lock up in the all-zero state.
module deal_lfsr
  import deal_engine_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter int CAND_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_advance,
  output logic [CAND_W-1:0] o_cand
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS16);

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_next;

  // One Galois step: shift right, fold taps in when the bit shifted out is 1.
  always_comb begin
    w_next = r_lfsr >> 1;
    if (r_lfsr[0]) begin
      w_next = (r_lfsr >> 1) ^ TAPS;
    end
  end

  // The candidate is taken from the value being advanced to in this cycle.
  assign o_cand = w_next[CAND_W-1:0];

  // State register: load with zero-guarded seed, else step when asked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_W'(1);
    end else if (i_load) begin
      r_lfsr <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
    end else if (i_advance) begin
      r_lfsr <= w_next;
    end
  end

endmodule

// File: rtl/deal_engine.sv
// Builds an ordered deck, optionally Fisher-Yates shuffles it, then streams each
// card once over valid/ready tagged with tableau column (or stock) and position.
module deal_engine
  import deal_engine_pkg::*;
#(
  parameter int NUM_COLS  = 7,
  parameter int DECK_SIZE = 52,
  parameter int LFSR_W    = 16,
  parameter int IDX_W     = $clog2(DECK_SIZE),
  parameter int DST_W     = $clog2(NUM_COLS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              shuffle_en,
  input  logic [LFSR_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CARD_W-1:0] out_card,
  output logic [DST_W-1:0]  out_dest,
  output logic [IDX_W-1:0]  out_pos,
  output logic              out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DECK_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(NUM_COLS - 1);
  localparam logic [DST_W-1:0] LAST_COL   = DST_W'(NUM_COLS - 1);
  localparam logic [DST_W-1:0] STOCK_DEST = DST_W'(NUM_COLS);

  deal_state_t r_state, w_state_next;

  card_id_t         r_deck [DECK_SIZE];
  logic [IDX_W-1:0] r_idx;      // build write index, then shuffle position i
  logic [IDX_W-1:0] r_rp;       // deck read pointer for the outgoing card
  logic [DST_W-1:0] r_col;      // destination of the outgoing card
  logic [IDX_W-1:0] r_pos;      // row in the tableau, or index within the stock
  logic             r_shuffle;
  logic             r_done;

  logic             w_lfsr_load;
  logic             w_lfsr_adv;
  logic [IDX_W-1:0] w_cand;
  logic             w_swap;
  logic             w_valid;
  logic             w_xfer;
  logic             w_last;
  logic             w_tab_end;
  logic             w_face;
  card_id_t         w_deck_i;
  card_id_t         w_deck_cand;
  card_id_t         w_deck_rp;

  deal_lfsr #(
    .LFSR_W (LFSR_W),
    .CAND_W (IDX_W)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_lfsr_load),
    .i_seed    (seed),
    .i_advance (w_lfsr_adv),
    .o_cand    (w_cand)
  );

  assign w_valid     = (r_state == ST_DEAL) || (r_state == ST_STOCK);
  assign w_xfer      = w_valid && out_ready;
  assign w_last      = (r_rp == LAST_IDX);
  assign w_tab_end   = (r_state == ST_DEAL) && (r_col == LAST_COL) && (r_pos == LAST_ROW);
  assign w_swap      = (r_state == ST_SHUFFLE) && (w_cand <= r_idx);
  assign w_deck_i    = r_deck[r_idx];
  assign w_deck_cand = r_deck[w_cand];
  assign w_deck_rp   = r_deck[r_rp];
  // The top card of each tableau column (column == row) is dealt face up.
  assign w_face      = (r_state == ST_DEAL) && (IDX_W'(r_col) == r_pos);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus LFSR control strobes.
  always_comb begin
    w_state_next = r_state;
    w_lfsr_load  = 1'b0;
    w_lfsr_adv   = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next = ST_BUILD;
          w_lfsr_load  = 1'b1;
        end
      end
      ST_BUILD: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = r_shuffle ? ST_SHUFFLE : ST_DEAL;
        end
      end
      ST_SHUFFLE: begin
        w_lfsr_adv = 1'b1;
        if (w_swap && (r_idx == IDX_W'(1))) begin
          w_state_next = ST_DEAL;
        end
      end
      ST_DEAL: begin
        if (w_xfer) begin
          if (w_last) begin
            w_state_next = ST_DONE;
          end else if (w_tab_end) begin
            w_state_next = ST_STOCK;
          end
        end
      end
      ST_STOCK: begin
        if (w_xfer && w_last) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Counters: build/shuffle index, read pointer, destination and position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_rp      <= '0;
      r_col     <= '0;
      r_pos     <= '0;
      r_shuffle <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_idx     <= '0;
            r_shuffle <= shuffle_en;
          end
        end
        ST_BUILD: begin
          // Leaves r_idx at DECK_SIZE-1, the first shuffle position.
          if (r_idx != LAST_IDX) begin
            r_idx <= r_idx + 1'b1;
          end
          r_rp  <= '0;
          r_col <= '0;
          r_pos <= '0;
        end
        ST_SHUFFLE: begin
          if (w_swap) begin
            r_idx <= r_idx - 1'b1;
          end
        end
        ST_DEAL: begin
          if (w_xfer) begin
            if (w_last) begin
              r_done <= 1'b1;
            end else begin
              r_rp <= r_rp + 1'b1;
              if (w_tab_end) begin
                r_col <= STOCK_DEST;
                r_pos <= '0;
              end else if (r_col == LAST_COL) begin
                // Next row starts at the column matching its row number.
                r_pos <= r_pos + 1'b1;
                r_col <= DST_W'(r_pos + 1'b1);
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        ST_STOCK: begin
          if (w_xfer) begin
            if (w_last) begin
              r_done <= 1'b1;
            end else begin
              r_rp  <= r_rp + 1'b1;
              r_pos <= r_pos + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Deck storage: ordered fill during build, one swap per accepted candidate.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DECK_SIZE; k++) begin
      if ((r_state == ST_BUILD) && (r_idx == IDX_W'(k))) begin
        r_deck[k] <= card_id(k);
      end else if (w_swap && (r_idx == IDX_W'(k))) begin
        r_deck[k] <= w_deck_cand;
      end else if (w_swap && (w_cand == IDX_W'(k))) begin
        r_deck[k] <= w_deck_i;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done      = r_done;
  assign out_valid = w_valid;
  assign out_card  = w_valid ? {w_deck_rp, w_face} : '0;
  assign out_dest  = w_valid ? r_col : '0;
  assign out_pos   = w_valid ? r_pos : '0;
  assign out_last  = w_valid && w_last;

endmodule

// File: tb/tb_deal_engine.sv
// Self-checking bench for deal_engine: reference deal computed from the card,
// shuffle and dealing rules, random backpressure, reset and restart scenarios.
module tb_deal_engine;

  localparam int DECK = 52;
  localparam int MAXN = DECK + 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start7, start4;
  logic        shuffle_en;
  logic [15:0] seed;
  logic        ready7, ready4;
  logic        busy7, done7, valid7, last7;
  logic        busy4, done4, valid4, last4;
  logic [6:0]  card7, card4;
  logic [2:0]  dest7, dest4;
  logic [5:0]  pos7, pos4;

  always #5 clk = ~clk;

  deal_engine u_dut7 (
    .clk (clk), .rst (rst), .start (start7), .shuffle_en (shuffle_en), .seed (seed),
    .busy (busy7), .done (done7), .out_valid (valid7), .out_ready (ready7),
    .out_card (card7), .out_dest (dest7), .out_pos (pos7), .out_last (last7)
  );

  deal_engine #(.NUM_COLS(4)) u_dut4 (
    .clk (clk), .rst (rst), .start (start4), .shuffle_en (shuffle_en), .seed (seed),
    .busy (busy4), .done (done4), .out_valid (valid4), .out_ready (ready4),
    .out_card (card4), .out_dest (dest4), .out_pos (pos4), .out_last (last4)
  );

  int errors = 0;
  int checks = 0;

  int exp_card [DECK];
  int exp_dest [DECK];
  int exp_pos  [DECK];
  int got_card [MAXN];
  int got_dest [MAXN];
  int got_pos  [MAXN];
  int got_last [MAXN];
  int got_n;
  int ref_card [DECK];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference deal: ordered deck, Fisher-Yates with the LFSR, then row-wise tableau and stock.
  task automatic model_deal(input bit shuf, input int unsigned sd, input int ncols);
    int deck [DECK];
    int unsigned lfsr;
    int i, cand, t, n;
    for (int k = 0; k < DECK; k++) deck[k] = ((k / 4 + 1) << 3) | ((k % 4) << 1);
    if (shuf) begin
      lfsr = (sd == 0) ? 1 : sd;
      i = DECK - 1;
      while (i >= 1) begin
        lfsr = (lfsr & 1) ? ((lfsr >> 1) ^ 32'hB400) : (lfsr >> 1);
        cand = int'(lfsr % 64);
        if (cand <= i) begin
          t = deck[i]; deck[i] = deck[cand]; deck[cand] = t;
          i--;
        end
      end
    end
    n = 0;
    for (int r = 0; r < ncols; r++) begin
      for (int c = r; c < ncols; c++) begin
        exp_card[n] = deck[n] | ((c == r) ? 1 : 0);
        exp_dest[n] = c;
        exp_pos[n]  = r;
        n++;
      end
    end
    for (int s = 0; n < DECK; s++) begin
      exp_card[n] = deck[n];
      exp_dest[n] = ncols;
      exp_pos[n]  = s;
      n++;
    end
  endtask

  function automatic logic sel_busy(input int which);
    return (which == 0) ? busy7 : busy4;
  endfunction

  task automatic do_start(input int which, input bit shuf, input logic [15:0] sd);
    @(negedge clk);
    shuffle_en = shuf;
    seed = sd;
    if (which == 0) start7 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start7 = 1'b0;
    start4 = 1'b0;
    check_value("busy_after_start", sel_busy(which), 1'b1);
  endtask

  // Drain the stream; optionally stop after max_n cards or re-pulse start after poke_at cards.
  task automatic collect(input int which, input int pct, input int max_n, input int poke_at);
    bit seen_last, prev_stall, poked, rdy, s_valid, s_last;
    int s_card, s_dest, s_pos, p_card, p_dest, p_pos, p_last, stall_bad;
    seen_last = 0; prev_stall = 0; poked = 0; stall_bad = 0;
    p_card = 0; p_dest = 0; p_pos = 0; p_last = 0;
    got_n = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      start7 = 1'b0;
      start4 = 1'b0;
      if (seen_last || (max_n > 0 && got_n >= max_n)) break;
      if (poke_at >= 0 && got_n == poke_at && !poked) begin
        poked = 1;
        shuffle_en = 1'b0;
        seed = 16'h0005;
        if (which == 0) start7 = 1'b1; else start4 = 1'b1;
      end
      rdy = ($urandom_range(0, 99) < pct);
      if (which == 0) ready7 = rdy; else ready4 = rdy;
      s_valid = (which == 0) ? valid7 : valid4;
      s_card  = int'((which == 0) ? card7 : card4);
      s_dest  = int'((which == 0) ? dest7 : dest4);
      s_pos   = int'((which == 0) ? pos7 : pos4);
      s_last  = (which == 0) ? last7 : last4;
      if (prev_stall && !(s_valid && s_card == p_card && s_dest == p_dest &&
                          s_pos == p_pos && int'(s_last) == p_last)) stall_bad++;
      if (s_valid && rdy && got_n < MAXN) begin
        got_card[got_n] = s_card;
        got_dest[got_n] = s_dest;
        got_pos[got_n]  = s_pos;
        got_last[got_n] = int'(s_last);
        $display("dut%0d xfer %0d card=%02h dest=%0d pos=%0d last=%0d",
                 (which == 0) ? 7 : 4, got_n, s_card, s_dest, s_pos, s_last);
        got_n++;
        if (s_last) seen_last = 1;
      end
      prev_stall = s_valid && !rdy;
      p_card = s_card; p_dest = s_dest; p_pos = s_pos; p_last = int'(s_last);
    end
    ready7 = 1'b0;
    ready4 = 1'b0;
    check_value("stall_stable", stall_bad, 0);
    if (max_n == 0) begin
      check_value("deal_completes", seen_last, 1'b1);
      check_value("done_pulse", (which == 0) ? done7 : done4, 1'b1);
      check_value("busy_cleared", sel_busy(which), 1'b0);
      check_value("valid_cleared", (which == 0) ? valid7 : valid4, 1'b0);
    end
  endtask

  task automatic compare_stream(input string tag);
    int mism;
    mism = 0;
    check_value({tag, "_count"}, got_n, DECK);
    for (int n = 0; n < DECK; n++) begin
      if (got_card[n] != exp_card[n] || got_dest[n] != exp_dest[n] ||
          got_pos[n] != exp_pos[n] || got_last[n] != ((n == DECK - 1) ? 1 : 0)) mism++;
    end
    check_value({tag, "_stream"}, mism, 0);
  endtask

  initial begin
    int cnt, bad, seen;
    bit [63:0] used;
    rst = 1'b1; start7 = 1'b0; start4 = 1'b0; shuffle_en = 1'b0; seed = '0;
    ready7 = 1'b0; ready4 = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_busy", busy7, 1'b0);
    check_value("rst_done", done7, 1'b0);
    check_value("rst_valid", valid7, 1'b0);
    check_value("rst_last", last7, 1'b0);
    check_value("rst_card", card7, 7'h00);
    check_value("rst_dest", dest7, 3'd0);
    check_value("rst_pos", pos7, 6'd0);
    rst = 1'b0;

    // Ordered deal, consumer always ready.
    model_deal(0, 0, 7);
    do_start(0, 1'b0, 16'h0000);
    collect(0, 100, 0, -1);
    compare_stream("t1");
    check_value("t1_card0", got_card[0], 32'h09);
    check_value("t1_dest0", got_dest[0], 0);
    check_value("t1_card1", got_card[1], 32'h0A);
    check_value("t1_dest1", got_dest[1], 1);
    check_value("t1_card28", got_card[28], 32'h40);
    check_value("t1_dest28", got_dest[28], 7);
    check_value("t1_pos28", got_pos[28], 0);
    cnt = 0;
    for (int n = 0; n < DECK; n++) cnt += got_last[n];
    check_value("t1_last_count", cnt, 1);

    // Seeded shuffle, run twice.
    model_deal(1, 32'hACE1, 7);
    do_start(0, 1'b1, 16'hACE1);
    collect(0, 100, 0, -1);
    compare_stream("t2a");
    for (int n = 0; n < DECK; n++) ref_card[n] = got_card[n];
    used = '0; seen = 0;
    for (int n = 0; n < DECK; n++) begin
      if (!used[(got_card[n] >> 1) & 63]) seen++;
      used[(got_card[n] >> 1) & 63] = 1'b1;
    end
    check_value("t2_distinct", seen, DECK);
    bad = 0;
    for (int c = 0; c < 7; c++) begin
      cnt = 0;
      for (int n = 0; n < DECK; n++) if (got_dest[n] == c) cnt++;
      if (cnt != c + 1) bad++;
    end
    check_value("t2_col_counts", bad, 0);
    bad = 0;
    for (int n = 0; n < DECK; n++)
      if ((got_card[n] & 1) != ((got_dest[n] < 7 && got_dest[n] == got_pos[n]) ? 1 : 0)) bad++;
    check_value("t2_face_up", bad, 0);
    do_start(0, 1'b1, 16'hACE1);
    collect(0, 100, 0, -1);
    compare_stream("t2b");
    bad = 0;
    for (int n = 0; n < DECK; n++) if (got_card[n] != ref_card[n]) bad++;
    check_value("t2_repeatable", bad, 0);

    // Zero seed behaves as seed 1.
    model_deal(1, 1, 7);
    do_start(0, 1'b1, 16'h0000);
    collect(0, 100, 0, -1);
    compare_stream("t3_seed0");

    // Backpressure: same seed with ready always high, then random ready.
    model_deal(1, 32'h1234, 7);
    do_start(0, 1'b1, 16'h1234);
    collect(0, 100, 0, -1);
    compare_stream("t4_ready");
    do_start(0, 1'b1, 16'h1234);
    collect(0, 40, 0, -1);
    compare_stream("t4_backpressure");

    // Reset mid-deal, then restart from card 0.
    model_deal(0, 0, 7);
    do_start(0, 1'b0, 16'h0000);
    collect(0, 100, 10, -1);
    check_value("t5_partial", got_n, 10);
    rst = 1'b1;
    @(negedge clk);
    check_value("t5_rst_valid", valid7, 1'b0);
    check_value("t5_rst_busy", busy7, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_value("t5_idle_valid", valid7, 1'b0);
    do_start(0, 1'b0, 16'h0000);
    collect(0, 100, 0, -1);
    compare_stream("t5_restart");
    check_value("t5_card0", got_card[0], 32'h09);

    // Start pulses while busy (during build and mid-deal) are ignored.
    model_deal(1, 32'hACE1, 7);
    do_start(0, 1'b1, 16'hACE1);
    @(negedge clk);
    shuffle_en = 1'b0; seed = 16'h0007; start7 = 1'b1;
    @(negedge clk);
    start7 = 1'b0;
    collect(0, 70, 0, 5);
    compare_stream("t6_ignore_start");

    // Four-column configuration: 10 tableau cards and 42 stock cards.
    model_deal(0, 0, 4);
    do_start(1, 1'b0, 16'h0000);
    collect(1, 100, 0, -1);
    compare_stream("t6_cols4");
    cnt = 0;
    for (int n = 0; n < DECK; n++) if (got_dest[n] == 4) cnt++;
    check_value("t6_stock_count", cnt, 42);
    cnt = 0;
    for (int n = 0; n < DECK; n++) if (got_dest[n] < 4) cnt++;
    check_value("t6_tableau_count", cnt, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
